// File: rtl/join_counter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// join_counter_pkg : shared types and default widths for the join counter.
// Rev 1.0
// =============================================================================
package join_counter_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    REQ_ARG   = 1'b0,
    REQ_ALLOC = 1'b1
  } req_kind_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_DEF-1:0] addr;
    logic [CNT_W_DEF-1:0]  count;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/join_counter_if.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// join_counter_if : AXI-Stream style valid/ready/data bundle.
// Rev 1.0
// =============================================================================
interface join_counter_if
  import join_counter_pkg::*;
#(
  parameter int W = ADDR_W_DEF
) ();

  logic [W-1:0] TDATA;
  logic         TVALID;
  logic         TREADY;

  modport master (output TDATA, output TVALID, input TREADY);
  modport slave  (input TDATA, input TVALID, output TREADY);

endinterface
`default_nettype wire

// File: rtl/join_table.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// join_table : pending-join storage with CAM lookup, free-slot encoder and
//              occupancy counter.
// Rev 1.0
// =============================================================================
module join_table
  import join_counter_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic [ADDR_W-1:0]            i_addr,
  input  wire logic                         i_dec,
  input  wire logic                         i_wr,
  input  wire logic [CNT_W-1:0]             i_wr_cnt,
  output logic                              o_hit,
  output logic [CNT_W-1:0]                  o_hit_cnt,
  output logic                              o_free,
  output logic [$clog2(ENTRIES+1)-1:0]      o_occupancy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OCC_W = $clog2(ENTRIES+1);

  logic [ENTRIES-1:0] r_valid;
  logic [ADDR_W-1:0]  r_addr [ENTRIES];
  logic [CNT_W-1:0]   r_cnt  [ENTRIES];
  logic [OCC_W-1:0]   r_occ;

  logic [ENTRIES-1:0] w_match;
  logic [IDX_W-1:0]   w_hit_idx;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_release;
  logic               w_alloc;

  generate
    for (genvar g = 0; g < ENTRIES; g++) begin : g_match
      assign w_match[g] = r_valid[g] && (r_addr[g] == i_addr);
    end
  endgenerate

  always_comb begin
    w_hit_idx  = '0;
    w_free_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (w_match[i])  w_hit_idx  = IDX_W'(i);
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
  end

  assign o_hit       = |w_match;
  assign o_hit_cnt   = r_cnt[w_hit_idx];
  assign o_free      = ~&r_valid;
  assign o_occupancy = r_occ;

  // An entry whose count reaches zero is retired in the same update.
  assign w_release = i_dec && o_hit && (o_hit_cnt == CNT_W'(1));
  assign w_alloc   = i_wr && o_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_occ   <= '0;
    end else if (w_release) begin
      r_valid[w_hit_idx] <= 1'b0;
      r_occ              <= r_occ - OCC_W'(1);
    end else if (w_alloc) begin
      r_valid[w_free_idx] <= 1'b1;
      r_occ               <= r_occ + OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_dec && o_hit) begin
      r_cnt[w_hit_idx] <= o_hit_cnt - CNT_W'(1);
    end else if (w_alloc) begin
      r_addr[w_free_idx] <= i_addr;
      r_cnt[w_free_idx]  <= i_wr_cnt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/join_counter.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// join_counter : matches continuation args against pending joins and releases
//                ready closure addresses.
// Rev 1.0
// =============================================================================
module join_counter
  import join_counter_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  wire logic                         ap_clk,
  input  wire logic                         ap_rst,
  join_counter_if.slave                     argIn,
  join_counter_if.slave                     allocIn,
  join_counter_if.master                    readyOut,
  output logic [$clog2(ENTRIES+1)-1:0]      occupancy,
  output logic                              err_orphan,
  output logic                              err_dup
);

  state_t            r_state;
  logic              r_pri;
  logic              r_live;
  req_kind_t         r_req_kind;
  logic [ADDR_W-1:0] r_req_addr;
  logic [CNT_W-1:0]  r_req_cnt;
  logic [ADDR_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_err_orphan;
  logic              r_err_dup;

  logic              w_hit;
  logic [CNT_W-1:0]  w_hit_cnt;
  logic              w_free;
  logic [CNT_W-1:0]  w_alloc_cnt;
  logic              w_alloc_ok;
  logic              w_grant_arg;
  logic              w_grant_alloc;
  logic              w_arg_hs;
  logic              w_alloc_hs;
  logic              w_is_alloc;
  logic              w_emit;
  logic              w_out_free;
  logic              w_apply;

  join_table #(
    .ENTRIES (ENTRIES),
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W)
  ) u_table (
    .clk         (ap_clk),
    .rst         (ap_rst),
    .i_addr      (r_req_addr),
    .i_dec       (w_apply && !w_is_alloc),
    .i_wr        (w_apply && w_is_alloc && (r_req_cnt != '0) && !w_hit),
    .i_wr_cnt    (r_req_cnt),
    .o_hit       (w_hit),
    .o_hit_cnt   (w_hit_cnt),
    .o_free      (w_free),
    .o_occupancy (occupancy)
  );

  assign w_alloc_cnt = allocIn.TDATA[ADDR_W +: CNT_W];
  assign w_alloc_ok  = w_free || (w_alloc_cnt == '0);

  always_comb begin
    w_grant_arg   = 1'b0;
    w_grant_alloc = 1'b0;
    if (r_live && (r_state == IDLE)) begin
      if (argIn.TVALID && allocIn.TVALID) begin
        // A full table with a non-zero alloc waiting must not block the args
        // that would free it.
        if (!w_alloc_ok || !r_pri) w_grant_arg   = 1'b1;
        else                       w_grant_alloc = 1'b1;
      end else if (argIn.TVALID) begin
        w_grant_arg = 1'b1;
      end else if (allocIn.TVALID) begin
        w_grant_alloc = 1'b1;
      end
    end
  end

  assign argIn.TREADY   = w_grant_arg;
  assign allocIn.TREADY = w_grant_alloc && w_alloc_ok;
  assign w_arg_hs       = w_grant_arg;
  assign w_alloc_hs     = w_grant_alloc && w_alloc_ok;

  assign w_is_alloc = (r_req_kind == REQ_ALLOC);
  assign w_emit     = w_is_alloc ? (r_req_cnt == '0)
                                 : (w_hit && (w_hit_cnt == CNT_W'(1)));
  assign w_out_free = !r_out_valid || readyOut.TREADY;
  assign w_apply    = (r_state == EXEC) && (!w_emit || w_out_free);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state      <= IDLE;
      r_pri        <= 1'b0;
      r_live       <= 1'b0;
      r_req_kind   <= REQ_ARG;
      r_req_addr   <= '0;
      r_req_cnt    <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_err_orphan <= 1'b0;
      r_err_dup    <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (r_out_valid && readyOut.TREADY) r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_arg_hs || w_alloc_hs) begin
            r_state    <= EXEC;
            r_pri      <= ~r_pri;
            r_req_kind <= w_alloc_hs ? REQ_ALLOC : REQ_ARG;
            r_req_addr <= w_alloc_hs ? allocIn.TDATA[ADDR_W-1:0] : argIn.TDATA;
            r_req_cnt  <= w_alloc_cnt;
          end
        end
        EXEC: begin
          if (w_apply) begin
            r_state <= IDLE;
            if (w_emit) begin
              r_out_valid <= 1'b1;
              r_out_data  <= r_req_addr;
            end
            if (!w_is_alloc && !w_hit) r_err_orphan <= 1'b1;
            if (w_is_alloc && (r_req_cnt != '0) && w_hit) r_err_dup <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign readyOut.TDATA  = r_out_data;
  assign readyOut.TVALID = r_out_valid;
  assign err_orphan      = r_err_orphan;
  assign err_dup         = r_err_dup;

endmodule
`default_nettype wire

// File: tb/tb_join_counter.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// tb_join_counter : scoreboard bench with a table-level reference model.
// Rev 1.0
// =============================================================================
module tb_join_counter;
  import join_counter_pkg::*;

  localparam int ENTRIES = 8;
  localparam int AW      = 64;
  localparam int CW      = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  join_counter_if #(.W(AW))    arg_if ();
  join_counter_if #(.W(AW+CW)) alloc_if ();
  join_counter_if #(.W(AW))    out_if ();
  logic [3:0] occupancy;
  logic       err_orphan;
  logic       err_dup;

  join_counter #(.ENTRIES(ENTRIES), .ADDR_W(AW), .CNT_W(CW)) dut (
    .ap_clk     (clk),
    .ap_rst     (rst),
    .argIn      (arg_if),
    .allocIn    (alloc_if),
    .readyOut   (out_if),
    .occupancy  (occupancy),
    .err_orphan (err_orphan),
    .err_dup    (err_dup)
  );

  entry_t        m_tab [ENTRIES];
  logic [AW-1:0] exp_q [$];
  bit            exp_orphan = 0;
  bit            exp_dup    = 0;
  bit            m_pri      = 0;
  bit            prev_hold  = 0;
  logic [AW-1:0] prev_data  = '0;
  int            n_checks   = 0;
  int            n_errors   = 0;
  bit            rnd_done   = 0;

  function automatic void chk(input bit ok, input string nm,
                              input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int m_count();
    int c = 0;
    foreach (m_tab[i]) if (m_tab[i].valid) c++;
    return c;
  endfunction

  function automatic int m_find(input logic [AW-1:0] a);
    foreach (m_tab[i]) if (m_tab[i].valid && m_tab[i].addr == a) return i;
    return -1;
  endfunction

  task automatic model_arg(input logic [AW-1:0] a);
    int i;
    i = m_find(a);
    if (i < 0) begin
      exp_orphan = 1;
    end else begin
      m_tab[i].count = m_tab[i].count - 16'd1;
      if (m_tab[i].count == 16'd0) begin
        m_tab[i].valid = 1'b0;
        exp_q.push_back(a);
      end
    end
  endtask

  task automatic model_alloc(input logic [AW-1:0] a, input logic [CW-1:0] c);
    if (c == 16'd0) begin
      exp_q.push_back(a);
    end else if (m_find(a) >= 0) begin
      exp_dup = 1;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (!m_tab[i].valid) begin
          m_tab[i] = '{valid: 1'b1, addr: a, count: c};
          break;
        end
      end
    end
  endtask

  // Monitor: everything sampled at negedge reflects what the next posedge acts on.
  always @(negedge clk) begin
    bit a_hs, l_hs, both, full, exp_arg;
    if (rst) begin
      foreach (m_tab[i]) m_tab[i].valid = 1'b0;
      exp_q.delete();
      exp_orphan = 0;
      exp_dup    = 0;
      m_pri      = 0;
      prev_hold  = 0;
    end else begin
      if (prev_hold)
        chk(out_if.TVALID && out_if.TDATA == prev_data, "out_stable",
            80'(out_if.TDATA), 80'(prev_data));
      if (out_if.TVALID && out_if.TREADY) begin
        if (exp_q.size() == 0) chk(0, "unexpected_out", 80'(out_if.TDATA), 80'(0));
        else begin
          logic [AW-1:0] e;
          e = exp_q.pop_front();
          chk(out_if.TDATA == e, "out_data", 80'(out_if.TDATA), 80'(e));
        end
      end
      prev_hold = out_if.TVALID && !out_if.TREADY;
      prev_data = out_if.TDATA;

      a_hs = arg_if.TVALID && arg_if.TREADY;
      l_hs = alloc_if.TVALID && alloc_if.TREADY;
      both = arg_if.TVALID && alloc_if.TVALID;
      full = (m_count() == ENTRIES);
      if (alloc_if.TVALID && full && alloc_if.TDATA[AW +: CW] != 16'd0)
        chk(!alloc_if.TREADY, "alloc_ready_full", 80'(alloc_if.TREADY), 80'(0));
      if (both && (a_hs || l_hs)) begin
        exp_arg = (full && alloc_if.TDATA[AW +: CW] != 16'd0) || !m_pri;
        chk(a_hs == exp_arg && l_hs == !exp_arg, "arb_winner",
            80'({a_hs, l_hs}), 80'({exp_arg, !exp_arg}));
      end
      if (a_hs) model_arg(arg_if.TDATA);
      else if (l_hs) model_alloc(alloc_if.TDATA[AW-1:0], alloc_if.TDATA[AW +: CW]);
      if (a_hs || l_hs) m_pri = !m_pri;
    end
  end

  task automatic send_arg(input logic [AW-1:0] a);
    arg_if.TDATA  = a;
    arg_if.TVALID = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (arg_if.TREADY) break;
      if (n > 400) begin chk(0, "arg_timeout", 80'(a), 80'(0)); break; end
    end
    @(posedge clk); #1;
    arg_if.TVALID = 1'b0;
  endtask

  task automatic send_alloc(input logic [AW-1:0] a, input logic [CW-1:0] c);
    alloc_if.TDATA  = {c, a};
    alloc_if.TVALID = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (alloc_if.TREADY) break;
      if (n > 400) begin chk(0, "alloc_timeout", 80'(a), 80'(c)); break; end
    end
    @(posedge clk); #1;
    alloc_if.TVALID = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
    chk(int'(occupancy) == m_count(), "occupancy", 80'(occupancy), 80'(m_count()));
    chk(err_orphan == exp_orphan, "err_orphan", 80'(err_orphan), 80'(exp_orphan));
    chk(err_dup == exp_dup, "err_dup", 80'(err_dup), 80'(exp_dup));
    chk(exp_q.size() == 0, "missing_out", 80'(exp_q.size()), 80'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    arg_if.TVALID   = 1'b1;
    arg_if.TDATA    = '0;
    alloc_if.TVALID = 1'b1;
    alloc_if.TDATA  = '0;
    out_if.TREADY   = 1'b1;
    repeat (3) @(negedge clk);
    chk(!arg_if.TREADY,   "rst_arg_ready",   80'(arg_if.TREADY),   80'(0));
    chk(!alloc_if.TREADY, "rst_alloc_ready", 80'(alloc_if.TREADY), 80'(0));
    chk(!out_if.TVALID && out_if.TDATA == '0, "rst_out",
        80'({out_if.TVALID, out_if.TDATA}), 80'(0));
    chk(occupancy == 4'd0 && !err_orphan && !err_dup, "rst_status",
        80'({occupancy, err_orphan, err_dup}), 80'(0));
    arg_if.TVALID   = 1'b0;
    alloc_if.TVALID = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Two-arg join with release latency.
    send_alloc(64'h1000, 16'd2);
    settle();
    send_arg(64'h1000);
    settle();
    send_arg(64'h1000);
    @(negedge clk);
    chk(!out_if.TVALID, "latency_n1", 80'(out_if.TVALID), 80'(0));
    @(negedge clk);
    chk(out_if.TVALID && out_if.TDATA == 64'h1000, "latency_n2",
        80'({out_if.TVALID, out_if.TDATA}), 80'({1'b1, 64'h1000}));
    settle();

    // Zero-count alloc emits immediately.
    send_alloc(64'hBEEF, 16'd0);
    settle();

    // Full table blocks non-zero allocs until an arg frees a slot.
    for (int i = 0; i < ENTRIES; i++) send_alloc(64'h2000 + 64'(i), 16'd1);
    settle();
    fork
      send_alloc(64'h3000, 16'd1);
      begin
        repeat (4) @(negedge clk);
        chk(!alloc_if.TREADY, "full_alloc_ready", 80'(alloc_if.TREADY), 80'(0));
        @(posedge clk); #1;
        send_arg(64'h2003);
      end
    join
    settle();
    send_arg(64'h3000);
    for (int i = 0; i < ENTRIES; i++) if (i != 3) send_arg(64'h2000 + 64'(i));
    settle();

    // Orphan arg, then duplicate alloc leaves the live count untouched.
    send_arg(64'hDEAD);
    settle();
    send_alloc(64'h4000, 16'd2);
    send_alloc(64'h4000, 16'd5);
    settle();
    send_arg(64'h4000);
    send_arg(64'h4000);
    settle();

    // Back-pressure holds the output and stalls the inputs.
    out_if.TREADY = 1'b0;
    fork
      begin
        send_alloc(64'h6000, 16'd0);
        send_alloc(64'h6001, 16'd0);
        send_alloc(64'h6002, 16'd0);
      end
      begin
        repeat (12) @(negedge clk);
        chk(!alloc_if.TREADY, "stall_alloc_ready", 80'(alloc_if.TREADY), 80'(0));
        chk(out_if.TVALID && out_if.TDATA == 64'h6000, "stall_hold",
            80'({out_if.TVALID, out_if.TDATA}), 80'({1'b1, 64'h6000}));
        @(posedge clk); #1;
        out_if.TREADY = 1'b1;
      end
    join
    settle();

    // Randomized traffic on both inputs with random back-pressure.
    fork
      begin
        fork
          for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send_arg(64'h7000 + 64'($urandom_range(0, 11)) * 64'd8);
          end
          for (int k = 0; k < 40; k++) begin
            logic [CW-1:0] c;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            c = CW'($urandom_range(0, 3));
            if (m_count() == ENTRIES) c = '0;
            send_alloc(64'h7000 + 64'($urandom_range(0, 11)) * 64'd8, c);
          end
        join
        rnd_done = 1;
      end
      while (!rnd_done) begin
        @(posedge clk); #1;
        out_if.TREADY = ($urandom_range(0, 3) != 0);
      end
    join
    out_if.TREADY = 1'b1;
    settle();

    // Reset while EXEC waits on a full output register.
    out_if.TREADY = 1'b0;
    send_alloc(64'h5000, 16'd3);
    send_alloc(64'h5001, 16'd0);
    send_alloc(64'h5002, 16'd0);
    chk(out_if.TVALID, "pre_rst_pending", 80'(out_if.TVALID), 80'(1));
    #2;
    rst = 1'b1;
    #1;
    chk(!out_if.TVALID && out_if.TDATA == '0, "async_rst_out",
        80'({out_if.TVALID, out_if.TDATA}), 80'(0));
    chk(occupancy == 4'd0 && !err_orphan && !err_dup, "async_rst_status",
        80'({occupancy, err_orphan, err_dup}), 80'(0));
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    out_if.TREADY = 1'b1;
    send_arg(64'h5000);
    settle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
